// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_ctrl
// Brief    : Direct-mapped, read-only instruction cache controller with
//            16-bit words, 4-word lines and single-request line fill.
// Revision : 1.0  initial release
// ============================================================================
module icache_ctrl #(
    parameter int LINES = 8,
    parameter int IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    output logic [15:0] instr,
    output logic        stall,
    input  logic        flush,
    output logic [13:0] m_addr,
    output logic        m_re,
    input  logic        m_rdy,
    input  logic [63:0] m_data,
    output logic [15:0] miss_cnt
);

    localparam int TAG_W = 14 - IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        INSTALL = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LINES-1:0]    valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [63:0]         data_mem [LINES];
    logic [13:0]         lat_addr;
    logic [63:0]         fill_data;

    logic [1:0]          offset;
    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    lat_idx;
    logic [TAG_W-1:0]    lat_tag;
    logic                hit;
    logic                miss_evt;

    assign offset   = i_addr[1:0];
    assign index    = i_addr[IDX_W+1:2];
    assign tag      = i_addr[15:IDX_W+2];
    assign lat_idx  = lat_addr[IDX_W-1:0];
    assign lat_tag  = lat_addr[13:IDX_W];
    assign hit      = valid[index] && (tag_mem[index] == tag);
    assign miss_evt = (state == IDLE) && i_rd && !hit;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        instr     = 16'h0000;
        m_re      = 1'b0;
        m_addr    = 14'h0000;
        case (state)
            IDLE: begin
                if (i_rd) begin
                    if (hit) begin
                        instr = data_mem[index][{offset, 4'b0000} +: 16];
                    end else begin
                        stall     = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                stall  = 1'b1;
                m_re   = 1'b1;
                m_addr = lat_addr;
                if (m_rdy) begin
                    state_nxt = INSTALL;
                end
            end
            INSTALL: begin
                stall     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= 14'h0000;
            fill_data <= 64'h0;
            miss_cnt  <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (miss_evt) begin
                lat_addr <= i_addr[15:2];
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'h0001;
                end
            end
            if (state == FILL && m_rdy) begin
                fill_data <= m_data;
            end
        end
    end

    // Install is ordered after flush so the line being written stays valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (flush) begin
                valid <= '0;
            end
            if (state == INSTALL) begin
                valid[lat_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == INSTALL) begin
            tag_mem[lat_idx]  <= lat_tag;
            data_mem[lat_idx] <= fill_data;
        end
    end

endmodule
`default_nettype wire

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter: LINES, 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 Parameter: IDX_W, 3, index width, equal to log2(LINES).
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: i_addr  input  16  CPU fetch word address (PC).
REQ-006 Port: i_rd  input  1  CPU fetch request.
REQ-007 Port: instr  output  16  fetched instruction word.
REQ-008 Port: stall  output  1  CPU must hold i_addr/i_rd and not advance PC while high.
REQ-009 Port: flush  input  1  invalidate all lines.
REQ-010 Port: m_addr  output  14  memory line address (i_addr[15:2]).
REQ-011 Port: m_re  output  1  memory line-read request.
REQ-012 Port: m_rdy  input  1  memory line data valid, one-cycle pulse.
REQ-013 Port: m_data  input  64  memory line, word 0 in bits [15:0], word 3 in bits [63:48].
REQ-014 Port: miss_cnt  output  16  saturating miss counter.

Function
REQ-015 Address split: offset = i_addr[1:0], index = i_addr[IDX_W+1:2], tag = i_addr[15:IDX_W+2].
REQ-016 Storage per line: valid bit, tag, 64-bit data; all held in registers.
REQ-017 FSM states: IDLE, FILL, INSTALL; reset state IDLE.
REQ-018 IDLE hit (i_rd=1, valid[index]=1, tag match): stall=0, instr = selected word same cycle (0-cycle latency), state stays IDLE.
REQ-019 IDLE miss (i_rd=1, no hit): stall=1 combinationally; latch i_addr[15:2]; miss_cnt increments; next state FILL.
REQ-020 IDLE with i_rd=0: stall=0, instr=16'h0000, no state change.
REQ-021 FILL: m_re=1, m_addr=latched line address, stall=1; on m_rdy=1 capture m_data, next state INSTALL; m_re stays high until the m_rdy cycle inclusive.
REQ-022 INSTALL: write captured data and latched tag into latched index, set valid, stall=1; next state IDLE, where the retried fetch hits.
REQ-023 Miss penalty: 1 detect cycle + memory wait cycles in FILL + 1 INSTALL cycle; with m_rdy on first FILL cycle, stall high for exactly 3 cycles.
REQ-024 m_re=0 and m_addr=14'h0000 in every state except FILL.
REQ-025 instr=16'h0000 whenever stall=1.
REQ-026 flush=1: all valid bits cleared at next posedge, in any state; flush does not alter FSM state.
REQ-027 Flush during FILL/INSTALL: fill completes; the INSTALL write sets its line valid even if flush asserted in the same cycle as INSTALL (install wins for that line).
REQ-028 Flush concurrent with an IDLE hit: current-cycle hit is still served; subsequent fetch misses.
REQ-029 i_addr changes while stall=1: ignored; fill uses latched address only.
REQ-030 m_rdy outside FILL: ignored.
REQ-031 miss_cnt saturates at 16'hFFFF; never wraps; unaffected by flush.
REQ-032 Conflict eviction: miss to an index holding a different tag overwrites that line unconditionally (read-only cache, no writeback).

Reset
REQ-033 While rst=1 (asynchronously): state=IDLE, all valid bits=0, miss_cnt=0, m_re=0, m_addr=0, latched address=0.
REQ-034 Outputs after reset release: stall=0 unless i_rd=1 (cold miss), instr=16'h0000.
REQ-035 Reset asserted mid-FILL: m_re drops immediately, partial fill discarded, no line made valid.
REQ-036 Tag/data arrays need not be reset; valid bits alone gate hits.

Verification
REQ-037 Cold miss: reset, i_rd=1, i_addr=16'h0005, m_rdy on first FILL cycle with m_data=64'h4444_3333_2222_1111 -> m_addr=14'h0001, stall high 3 cycles, then instr=16'h2222 with stall=0, miss_cnt=1.
REQ-038 Same-line hits: after 037, i_addr=16'h0004,6,7 -> instr=1111,3333,4444 each with stall=0, miss_cnt stays 1.
REQ-039 Conflict: i_addr=16'h0025 (index 1, new tag) with 5-cycle memory delay -> stall high 7 cycles, line 1 replaced; re-fetch 16'h0005 -> miss, miss_cnt=3.
REQ-040 Flush: after a hit at 16'h0004, pulse flush one cycle -> next fetch of 16'h0004 misses (stall=1, m_re next cycle).
REQ-041 Reset mid-fill: rst asserted during FILL -> m_re=0 same cycle, miss_cnt=0; after release, refetch misses again.
REQ-042 Saturation: force 65,536+ misses (alternating conflicting tags) -> miss_cnt holds 16'hFFFF.
